// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
//
// Elastic pipeline register that sits between two pipeline stages and
// carries an opaque WIDTH-bit payload through a DEPTH-entry in-order
// circular buffer. A valid/ready handshake on each side lets a downstream
// stall be absorbed locally instead of rippling combinationally upstream.
//
// Parameters
//   WIDTH        payload width in bits (>= 1)
//   DEPTH        number of buffer entries (1..8); 2 gives a full-rate skid stage
//   ZERO_INVALID when 1, out_data reads as all zeros while out_valid is low
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (pointers and count only)
//   flush      in   drop every buffered entry and any same-cycle push/pop
//   in_valid   in   upstream offers in_data
//   in_ready   out  buffer has a free entry (registered state only)
//   in_data    in   upstream payload
//   out_valid  out  head entry is present
//   out_ready  in   downstream consumes the head entry
//   out_data   out  head entry payload (or zeros when empty and ZERO_INVALID)
//   count      out  current occupancy

module pipe_stage_buf #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned DEPTH        = 2,
   parameter bit          ZERO_INVALID = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [CW-1:0]    r_count;

   logic             w_inReady;
   logic             w_outValid;
   logic             w_push;
   logic             w_pop;
   logic [PW-1:0]    w_headNext;
   logic [PW-1:0]    w_tailNext;

   // Handshake status comes purely from the registered count, so there is
   // no combinational path from out_ready back to in_ready. A full buffer
   // refuses a push even when a pop happens in the same cycle.
   assign w_inReady  = (r_count < FULL_CNT);
   assign w_outValid = (r_count != '0);

   // Flush suppresses both transfers so neither side sees a completed
   // handshake during a flush cycle.
   assign w_push = in_valid  & w_inReady  & ~flush;
   assign w_pop  = out_valid & out_ready  & ~flush;

   // Explicit wrap so that non-power-of-two depths stay in range.
   assign w_headNext = (r_head == LAST_IDX) ? '0 : r_head + 1'b1;
   assign w_tailNext = (r_tail == LAST_IDX) ? '0 : r_tail + 1'b1;

   // Pointer and occupancy state. Reset beats flush, flush beats any
   // push/pop. A simultaneous push and pop leaves count unchanged while
   // both pointers advance.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= w_tailNext;
         end
         if (w_pop) begin
            r_head <= w_headNext;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // Payload storage is never cleared; only pointers and count decide what
   // is live, which keeps the datapath free of reset fan-out.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_tail] <= in_data;
      end
   end

   // With ZERO_INVALID the empty output reads as a bubble/NOP; the mux
   // select is the registered count, so out_data remains register-driven.
   always_comb begin
      out_data = r_mem[r_head];
      if (ZERO_INVALID && !w_outValid) begin
         out_data = '0;
      end
   end

   assign in_ready  = w_inReady;
   assign out_valid = w_outValid;
   assign count     = r_count;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf
//
// Directed bench for pipe_stage_buf. Several instances with different
// DEPTH/ZERO_INVALID settings share one clock and reset; each scenario
// drives only its own instance. Inputs change 1 time unit after the rising
// edge and outputs are sampled at that same point, well clear of the edge.

module tb_pipe_stage_buf;

   logic clk;
   logic rst;

   int compared;
   int mismatched;

   // DEPTH=2, ZERO_INVALID=1: reset, streaming and flush scenarios
   logic        d2Flush, d2InValid, d2InReady, d2OutValid, d2OutReady;
   logic [31:0] d2InData, d2OutData;
   logic [1:0]  d2Count;

   // DEPTH=4: backpressure / full
   logic        d4InValid, d4InReady, d4OutValid, d4OutReady;
   logic [31:0] d4InData, d4OutData;
   logic [2:0]  d4Count;

   // DEPTH=3: randomised wrap-around against a queue scoreboard
   logic        d3InValid, d3InReady, d3OutValid, d3OutReady;
   logic [31:0] d3InData, d3OutData;
   logic [1:0]  d3Count;

   // DEPTH=1, both ZERO_INVALID settings, driven by the same inputs
   logic        d1InValid, d1OutReady;
   logic [31:0] d1InData;
   logic        z1InReady, z1OutValid, n1InReady, n1OutValid;
   logic [31:0] z1OutData, n1OutData;
   logic        z1Count, n1Count;

   pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .ZERO_INVALID(1'b1)) uDepth2 (
      .clk(clk), .rst(rst), .flush(d2Flush),
      .in_valid(d2InValid), .in_ready(d2InReady), .in_data(d2InData),
      .out_valid(d2OutValid), .out_ready(d2OutReady), .out_data(d2OutData),
      .count(d2Count)
   );

   pipe_stage_buf #(.WIDTH(32), .DEPTH(4), .ZERO_INVALID(1'b1)) uDepth4 (
      .clk(clk), .rst(rst), .flush(1'b0),
      .in_valid(d4InValid), .in_ready(d4InReady), .in_data(d4InData),
      .out_valid(d4OutValid), .out_ready(d4OutReady), .out_data(d4OutData),
      .count(d4Count)
   );

   pipe_stage_buf #(.WIDTH(32), .DEPTH(3), .ZERO_INVALID(1'b1)) uDepth3 (
      .clk(clk), .rst(rst), .flush(1'b0),
      .in_valid(d3InValid), .in_ready(d3InReady), .in_data(d3InData),
      .out_valid(d3OutValid), .out_ready(d3OutReady), .out_data(d3OutData),
      .count(d3Count)
   );

   pipe_stage_buf #(.WIDTH(32), .DEPTH(1), .ZERO_INVALID(1'b1)) uDepth1Zero (
      .clk(clk), .rst(rst), .flush(1'b0),
      .in_valid(d1InValid), .in_ready(z1InReady), .in_data(d1InData),
      .out_valid(z1OutValid), .out_ready(d1OutReady), .out_data(z1OutData),
      .count(z1Count)
   );

   pipe_stage_buf #(.WIDTH(32), .DEPTH(1), .ZERO_INVALID(1'b0)) uDepth1Stale (
      .clk(clk), .rst(rst), .flush(1'b0),
      .in_valid(d1InValid), .in_ready(n1InReady), .in_data(d1InData),
      .out_valid(n1OutValid), .out_ready(d1OutReady), .out_data(n1OutData),
      .count(n1Count)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle 1 unit past it
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // One comparison: count it, and report it if the DUT disagrees
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Directed scenario sequence
   initial begin
      logic [31:0] sbQueue[$];
      int          modelCount;
      int          transfers;
      logic        doPush;
      logic        doPop;
      logic        expFull;

      compared   = 0;
      mismatched = 0;

      rst        = 1'b1;
      d2Flush    = 1'b0; d2InValid = 1'b0; d2InData = '0; d2OutReady = 1'b0;
      d4InValid  = 1'b0; d4InData  = '0;  d4OutReady = 1'b0;
      d3InValid  = 1'b0; d3InData  = '0;  d3OutReady = 1'b0;
      d1InValid  = 1'b0; d1InData  = '0;  d1OutReady = 1'b0;

      // ---- Reset with an offered payload: nothing must be captured ----
      d2InValid = 1'b1;
      d2InData  = 32'hDEAD_BEEF;
      for (int i = 0; i < 2; i++) begin
         applyStimulus();
         checkOutput("rst_count",    32'(d2Count),    32'd0);
         checkOutput("rst_outValid", 32'(d2OutValid), 32'd0);
         checkOutput("rst_outData",  d2OutData,       32'd0);
         checkOutput("rst_inReady",  32'(d2InReady),  32'd1);
      end
      rst       = 1'b0;
      d2InValid = 1'b0;
      d2InData  = '0;
      applyStimulus();
      checkOutput("idle_count", 32'(d2Count), 32'd0);

      // ---- Streaming 0x1..0x10 through DEPTH=2 with out_ready held ----
      d2OutReady = 1'b1;
      d2InValid  = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         d2InData = 32'(i);
         checkOutput("stream_inReady", 32'(d2InReady), 32'd1);
         applyStimulus();
         checkOutput("stream_outValid", 32'(d2OutValid), 32'd1);
         checkOutput("stream_outData",  d2OutData,       32'(i));
         checkOutput("stream_count",    32'(d2Count),    32'd1);
      end
      d2InValid = 1'b0;
      applyStimulus();
      checkOutput("stream_drain_count",   32'(d2Count),    32'd0);
      checkOutput("stream_drain_valid",   32'(d2OutValid), 32'd0);
      checkOutput("stream_drain_outData", d2OutData,       32'd0);

      // ---- Backpressure on DEPTH=4: push A..E with out_ready low ----
      for (int k = 0; k < 5; k++) begin
         d4InValid = 1'b1;
         d4InData  = 32'hA + 32'(k);
         applyStimulus();
         checkOutput("full_count", 32'(d4Count), (k < 4) ? 32'(k + 1) : 32'd4);
         checkOutput("full_inReady", 32'(d4InReady), (k < 3) ? 32'd1 : 32'd0);
      end
      d4InValid  = 1'b0;
      d4OutReady = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checkOutput("drain_outData", d4OutData, 32'hA + 32'(k));
         applyStimulus();
         checkOutput("drain_inReady", 32'(d4InReady), 32'd1);
         checkOutput("drain_count",   32'(d4Count),   32'(3 - k));
      end
      // 0xE was never accepted, so the buffer is empty after four pops
      checkOutput("drain_empty_valid", 32'(d4OutValid), 32'd0);
      d4OutReady = 1'b0;

      // ---- Flush precedence on DEPTH=2 ----
      d2OutReady = 1'b0;
      d2InValid  = 1'b1;
      d2InData   = 32'h11;
      applyStimulus();
      d2InData   = 32'h22;
      applyStimulus();
      checkOutput("preflush_count", 32'(d2Count), 32'd2);
      d2Flush    = 1'b1;
      d2InData   = 32'h33;
      d2OutReady = 1'b1;
      // Outputs still show the pre-flush head during the flush cycle
      checkOutput("flushcyc_valid",   32'(d2OutValid), 32'd1);
      checkOutput("flushcyc_outData", d2OutData,       32'h11);
      applyStimulus();
      d2Flush   = 1'b0;
      d2InValid = 1'b0;
      d2OutReady = 1'b0;
      checkOutput("postflush_count",   32'(d2Count),    32'd0);
      checkOutput("postflush_valid",   32'(d2OutValid), 32'd0);
      checkOutput("postflush_outData", d2OutData,       32'd0);
      checkOutput("postflush_inReady", 32'(d2InReady),  32'd1);
      applyStimulus();
      checkOutput("postflush_no33", 32'(d2Count), 32'd0);
      d2InValid = 1'b1;
      d2InData  = 32'h44;
      applyStimulus();
      d2InValid = 1'b0;
      checkOutput("after_flush_outData", d2OutData,    32'h44);
      checkOutput("after_flush_count",   32'(d2Count), 32'd1);
      d2OutReady = 1'b1;
      applyStimulus();
      checkOutput("after_flush_empty", 32'(d2Count), 32'd0);
      d2OutReady = 1'b0;

      // ---- Wrap-around on DEPTH=3 with random handshakes ----
      modelCount = 0;
      for (int c = 0; c < 1000; c++) begin
         d3InValid  = 1'($urandom_range(0, 1));
         d3OutReady = 1'($urandom_range(0, 1));
         d3InData   = $urandom();
         expFull    = (modelCount >= 3);
         checkOutput("wrap_count",    32'(d3Count),    32'(modelCount));
         checkOutput("wrap_inReady",  32'(d3InReady),  expFull ? 32'd0 : 32'd1);
         checkOutput("wrap_outValid", 32'(d3OutValid), (modelCount > 0) ? 32'd1 : 32'd0);
         checkOutput("wrap_outData",  d3OutData,
                     (modelCount > 0) ? sbQueue[0] : 32'd0);
         doPush = d3InValid && !expFull;
         doPop  = d3OutReady && (modelCount > 0);
         if (doPop) begin
            void'(sbQueue.pop_front());
            modelCount--;
         end
         if (doPush) begin
            sbQueue.push_back(d3InData);
            modelCount++;
         end
         applyStimulus();
      end
      d3InValid  = 1'b0;
      d3OutReady = 1'b0;

      // ---- DEPTH=1, ZERO_INVALID 1 vs 0, alternating push/pop of all ones ----
      d1InValid  = 1'b1;
      d1InData   = 32'hFFFF_FFFF;
      d1OutReady = 1'b1;
      transfers  = 0;
      for (int i = 0; i < 8; i++) begin
         // Occupancy alternates 0,1,0,1... because a full DEPTH=1 buffer
         // refuses the push in the same cycle it pops
         checkOutput("d1_count",    32'(z1Count),   32'(i % 2));
         checkOutput("d1_inReady",  32'(z1InReady), (i % 2 == 0) ? 32'd1 : 32'd0);
         checkOutput("d1_zero_outData", z1OutData,
                     (i % 2 == 1) ? 32'hFFFF_FFFF : 32'd0);
         if (i > 0) begin
            checkOutput("d1_stale_outData", n1OutData, 32'hFFFF_FFFF);
         end
         if (z1OutValid && d1OutReady) begin
            transfers++;
         end
         applyStimulus();
      end
      checkOutput("d1_throughput", 32'(transfers), 32'd4);
      d1InValid  = 1'b0;
      d1OutReady = 1'b0;

      // ---- Reset mid-operation drops live entries ----
      d4InValid = 1'b1;
      d4InData  = 32'h55;
      applyStimulus();
      d4InValid = 1'b0;
      checkOutput("midrst_pre_count", 32'(d4Count), 32'd1);
      rst = 1'b1;
      applyStimulus();
      rst = 1'b0;
      checkOutput("midrst_count",   32'(d4Count),    32'd0);
      checkOutput("midrst_valid",   32'(d4OutValid), 32'd0);
      checkOutput("midrst_outData", d4OutData,       32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic pipeline register that replaces fixed, bundle-specific stage latches between pipeline stages (fetch→decode, decode→execute, execute→mem). It carries an opaque `WIDTH`-bit payload through a `DEPTH`-entry in-order buffer. It adds a valid/ready handshake, synchronous flush, and optional zeroing of invalid output, so a downstream stall no longer forces a combinational stall back up the pipe.

## Interface
Parameters:
- `WIDTH`, 32: payload width in bits (≥1).
- `DEPTH`, 2: buffer entries (1–8); 2 gives a full-throughput skid stage.
- `ZERO_INVALID`, 1: when 1, `out_data` is forced to all zeros whenever `out_valid`=0, so it reads as a bubble/NOP.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous active-high reset.
- `flush`  in  1  discard all buffered entries and any same-cycle push.
- `in_valid`  in  1  upstream offers `in_data`.
- `in_ready`  out  1  buffer can accept; a push occurs when `in_valid & in_ready & !flush`.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  head entry is present.
- `out_ready`  in  1  downstream consumes; a pop occurs when `out_valid & out_ready & !flush`.
- `out_data`  out  WIDTH  head entry payload.
- `count`  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Circular buffer with head pointer, tail pointer and count registers; pointers wrap modulo `DEPTH`. Non-power-of-2 `DEPTH` must wrap explicitly.
- `in_ready` = (`count` < `DEPTH`). It depends on registered state only, so there is no combinational path from `out_ready` to `in_ready`.
- `out_valid` = (`count` ≠ 0). `out_data` = head entry, or zeros if `ZERO_INVALID` and empty.
- Push: write `in_data` at tail; tail increments.
- Pop: head increments.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance. This is legal only when not full, because `in_ready`=0 when full even if a pop occurs.
- `flush` priority: `rst` > `flush` > push/pop. When `flush` is asserted, at the next edge `count`=0 and head=tail=0, and the same-cycle push and pop are both suppressed. Downstream must not treat an `out_valid & out_ready` handshake in a flush cycle as a consume.
- Storage contents need not be cleared on flush or reset. Only the pointers and count are reset.
- `in_valid` without `in_ready` is a stall. `in_data` is not sampled. Upstream holds data; the block does not require it.

## Timing
- Reset (`rst`=1 at an edge): `count`=0, head=tail=0. After the edge, `out_valid`=0, `in_ready`=1, and `out_data`=0 when `ZERO_INVALID`=1. Reset mid-operation drops all entries identically.
- Latency: data pushed at edge N appears on `out_data` with `out_valid`=1 after edge N (visible in cycle N+1). There is no same-cycle bypass.
- Throughput: with `DEPTH`≥2 and `out_ready` held at 1, one transfer per cycle is sustained indefinitely. With `DEPTH`=1, the maximum is one transfer every 2 cycles.
- Full (`count`=`DEPTH`): `in_ready`=0 for the whole cycle; a pop that cycle raises `in_ready` next cycle.
- Empty: `out_valid`=0; `out_ready` is ignored.
- Flush cycle: outputs still reflect pre-flush state during that cycle. The effect is visible after the edge.
- All outputs are functions of registers only. There are no combinational input→output paths except `ZERO_INVALID` muxing, which is driven by registered `count`.

## Test plan
- Reset/idle: assert `rst` 2 cycles with `in_valid`=1 and `in_data`=0xDEADBEEF. Required: `count`=0, `out_valid`=0, `out_data`=0, `in_ready`=1 after each reset edge.
- Streaming: `DEPTH`=2, push 0x1..0x10 on consecutive cycles with `out_ready`=1. Required: `out_data` = 0x1..0x10 in order, each one cycle after push, no `in_ready` deassertion, and `count` ≤1 throughout.
- Backpressure/full: `DEPTH`=4, `out_ready`=0, push 0xA,0xB,0xC,0xD,0xE. Required: `count`=4 and `in_ready`=0 after 4th push, 0xE not accepted. Then `out_ready`=1 drains A,B,C,D; `in_ready`=1 one cycle after first pop.
- Flush precedence: `count`=2 (0x11,0x22), assert `flush` with `in_valid`=1 (0x33) and `out_ready`=1. Required: next cycle `count`=0 and `out_valid`=0, with 0x33 never appearing. A following push of 0x44 emerges as the next `out_data`.
- Wrap-around: `DEPTH`=3, randomised `in_valid`/`out_ready` for 1000 cycles against a scoreboard. Required: exact in-order match, `count` always 0–3, and pointers wrap past index 2 correctly.
- `ZERO_INVALID`=0 vs 1 with `DEPTH`=1 alternating push/pop of 0xFFFF_FFFF. Required: empty cycles show `out_data`=0 for `ZERO_INVALID`=1 and stale 0xFFFF_FFFF allowed for `ZERO_INVALID`=0. Throughput is 1 transfer per 2 cycles.
